// File: rtl/draw_rect_engine_pkg.sv
// Shared draw package: FSM state encoding and default visible-area bounds
// used by the rectangle engine and the other graphics blocks.
// Latency: n/a (types and constants only). Backpressure: n/a.
package draw_rect_engine_pkg;

    // Engine states: waiting for a request, scanning pixels, end-of-rectangle pulse.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } draw_state_t;

    // Default visible area (160x120 frame buffer).
    localparam int DRAW_SCREEN_W = 160;
    localparam int DRAW_SCREEN_H = 120;

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major column/row stepper for a w x h rectangle; last flags (w-1, h-1).
// Latency: counters update on the clock edge after clear/step; last is combinational.
// Backpressure: advances only when step=1, otherwise holds.
//
// Ports: clk, reset (async, active-high); clear zeroes cx/cy; step advances
// one pixel; w/h are the rectangle size; cx/cy the current offset.
module rect_scan_counter #(
    parameter int SZ_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            step,
    input  logic [SZ_W-1:0] w,
    input  logic [SZ_W-1:0] h,
    output logic [SZ_W-1:0] cx,
    output logic [SZ_W-1:0] cy,
    output logic            last
);

    logic col_end;
    logic row_end;

    assign col_end = (cx == w - SZ_W'(1));
    assign row_end = (cy == h - SZ_W'(1));
    assign last    = col_end & row_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx <= '0;
            cy <= '0;
        end else if (clear) begin
            cx <= '0;
            cy <= '0;
        end else if (step) begin
            if (col_end) begin
                cx <= '0;
                // Wrap both counters after the last pixel so the engine rests at (0,0).
                cy <= row_end ? '0 : cy + SZ_W'(1);
            end else begin
                cx <= cx + SZ_W'(1);
            end
        end
    end

endmodule

// File: rtl/draw_rect_engine.sv
// Rectangle fill engine: scans a w x h box row-major, emitting clipped pixels.
// Latency: first pixel the cycle after start; done pulses the cycle after the last pixel.
// Backpressure: pixels advance only when pix_ready=1; outputs hold while it is low.
//
// Ports: clk, reset (async, active-high); start + x_in/y_in/w_in/h_in/colour_in
// request (latched in IDLE only); pix_ready from the frame-buffer writer;
// x_out/y_out/colour_out/plot current pixel; busy, done status.
// Optional macro DRAW_RECT_OUTLINE_EN adds input outline: when latched high,
// only border pixels are plotted (scan timing is unchanged).
module draw_rect_engine
    import draw_rect_engine_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SZ_W     = 5,
    parameter int C_W      = 3,
    parameter int SCREEN_W = DRAW_SCREEN_W,
    parameter int SCREEN_H = DRAW_SCREEN_H
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [X_W-1:0]  x_in,
    input  logic [Y_W-1:0]  y_in,
    input  logic [SZ_W-1:0] w_in,
    input  logic [SZ_W-1:0] h_in,
    input  logic [C_W-1:0]  colour_in,
`ifdef DRAW_RECT_OUTLINE_EN
    input  logic            outline,
`endif
    input  logic            pix_ready,
    output logic [X_W-1:0]  x_out,
    output logic [Y_W-1:0]  y_out,
    output logic [C_W-1:0]  colour_out,
    output logic            plot,
    output logic            busy,
    output logic            done
);

    draw_state_t     state;
    logic [X_W-1:0]  x_base;
    logic [Y_W-1:0]  y_base;
    logic [SZ_W-1:0] w_lat;
    logic [SZ_W-1:0] h_lat;
    logic [C_W-1:0]  colour_lat;
    logic            busy_r;
    logic            done_r;

    logic [SZ_W-1:0] cx;
    logic [SZ_W-1:0] cy;
    logic            last;
    logic            accept;
    logic            step;
    logic            empty_rect;

    // Full-width coordinates: the extra MSB catches carry-out so a wrapped
    // coordinate is never mistaken for an on-screen one.
    logic [X_W:0]    x_sum;
    logic [Y_W:0]    y_sum;
    logic            x_vis;
    logic            y_vis;
    logic            border_ok;

    assign accept     = (state == ST_IDLE) && start;
    assign step       = (state == ST_DRAW) && pix_ready;
    assign empty_rect = (w_in == '0) || (h_in == '0);

    rect_scan_counter #(
        .SZ_W (SZ_W)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .step  (step),
        .w     (w_lat),
        .h     (h_lat),
        .cx    (cx),
        .cy    (cy),
        .last  (last)
    );

    assign x_sum = {1'b0, x_base} + (X_W+1)'(cx);
    assign y_sum = {1'b0, y_base} + (Y_W+1)'(cy);
    assign x_vis = (x_sum < (X_W+1)'(SCREEN_W));
    assign y_vis = (y_sum < (Y_W+1)'(SCREEN_H));

`ifdef DRAW_RECT_OUTLINE_EN
    logic outline_lat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outline_lat <= 1'b0;
        end else if (accept) begin
            outline_lat <= outline;
        end
    end

    assign border_ok = !outline_lat
                     || (cx == '0) || (cx == w_lat - SZ_W'(1))
                     || (cy == '0) || (cy == h_lat - SZ_W'(1));
`else
    assign border_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            x_base     <= '0;
            y_base     <= '0;
            w_lat      <= '0;
            h_lat      <= '0;
            colour_lat <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_base     <= x_in;
                        y_base     <= y_in;
                        w_lat      <= w_in;
                        h_lat      <= h_in;
                        colour_lat <= colour_in;
                        busy_r     <= 1'b1;
                        // A zero-sized rectangle skips straight to the done pulse.
                        done_r     <= empty_rect;
                        state      <= empty_rect ? ST_DONE : ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (pix_ready && last) begin
                        done_r <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign x_out      = x_sum[X_W-1:0];
    assign y_out      = y_sum[Y_W-1:0];
    assign colour_out = colour_lat;
    assign plot       = (state == ST_DRAW) && x_vis && y_vis && border_ok;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: doc/draw_rect_engine.md
DRAW_RECT_ENGINE -- requirements
Module: draw_rect_engine

Interface
REQ-001 Parameter X_W, default 8, x-coordinate width in bits.
REQ-002 Parameter Y_W, default 7, y-coordinate width in bits.
REQ-003 Parameter SZ_W, default 5, width in bits of the rectangle width/height inputs (maximum 2^SZ_W-1 pixels per side).
REQ-004 Parameter C_W, default 3, colour width in bits.
REQ-005 Parameter SCREEN_W, default 160, and SCREEN_H, default 120, are the visible-area bounds used for clipping.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  request to draw one rectangle; sampled only in IDLE.
REQ-009 x_in / y_in  in  X_W / Y_W  top-left corner, latched on accept.
REQ-010 w_in / h_in  in  SZ_W each  rectangle width/height in pixels, latched on accept.
REQ-011 colour_in  in  C_W  fill colour, latched on accept.
REQ-012 pix_ready  in  1  downstream (frame-buffer writer) accepts the current pixel this cycle.
REQ-013 x_out / y_out  out  X_W / Y_W  current pixel coordinate.
REQ-014 colour_out  out  C_W  latched colour.
REQ-015 plot  out  1  current pixel is valid and must be written.
REQ-016 busy  out  1  high whenever the engine is not in IDLE.
REQ-017 done  out  1  single-cycle pulse after the last pixel of a rectangle.

Function
REQ-018 FSM states: IDLE, DRAW, DONE; IDLE->DRAW on start with w_in!=0 and h_in!=0; IDLE->DONE on start with w_in==0 or h_in==0 (nothing plotted); DRAW->DONE when the last pixel is accepted; DONE->IDLE unconditionally after one cycle.
REQ-019 On accept, column counter cx and row counter cy are cleared to 0; the first pixel appears the cycle after start.
REQ-020 Scan order is row-major: cx increments 0..w-1, then wraps to 0 while cy increments; the last pixel is (w-1, h-1).
REQ-021 Counters advance only in DRAW on cycles with pix_ready=1; with pix_ready=0, x_out, y_out, colour_out and plot hold.
REQ-022 x_out = x_base + cx and y_out = y_base + cy, computed with one extra carry bit internally.
REQ-023 plot = 1 in DRAW only when the full-width sum satisfies x < SCREEN_W and y < SCREEN_H; off-screen pixels (including carry-out wrap) have plot=0 but are still stepped through at one per pix_ready cycle.
REQ-024 start while busy=1 is ignored; inputs other than start and pix_ready are ignored outside the accept cycle.
REQ-025 done=1 only in DONE; busy=1 in DRAW and DONE.

Reset
REQ-026 Asserting reset at any time, including mid-rectangle, immediately forces IDLE, cx=cy=0, latched base/size/colour to 0, x_out=0, y_out=0, colour_out=0, plot=0, busy=0, done=0.
REQ-027 After reset deassertion, no pixel is emitted until a new start is accepted.

Configuration
REQ-028 Macro DRAW_RECT_OUTLINE_EN: when defined, an input outline (1 bit) is latched on accept, and if set, plot is additionally gated to border pixels only (cx==0, cx==w-1, cy==0 or cy==h-1), while scan timing is unchanged; when undefined, the port is absent and every rectangle is filled.

Structure
REQ-029 The FSM state encoding and the default SCREEN_W/SCREEN_H constants shall live in the shared draw package, together with the other graphics blocks.
REQ-030 The row/column stepping shall be a sub-module, rect_scan_counter (inputs: clear, step, w, h; outputs: cx, cy, last).

Verification
REQ-031 Reset, then start with x=14, y=99, w=11, h=11, colour=3'b101, pix_ready=1: exactly 121 plot cycles, the first at (14,99) and the last at (24,109), then done pulses once, then busy falls.
REQ-032 w=0, h=5: no plot, done is asserted the cycle after start, and busy is high for exactly that cycle.
REQ-033 x=155, y=0, w=10, h=1: 10 scan cycles; plot=1 only for x=155..159.
REQ-034 pix_ready toggling 1,0,1,0 during a 2x2 rectangle: outputs hold on the 0 cycles; four pixels are plotted in order (0,0),(1,0),(0,1),(1,1) relative to the base.
REQ-035 reset asserted after the 5th pixel of a 4x4 rectangle: same-cycle return to all-zero outputs and no done pulse; a start asserted during busy is ignored.
REQ-036 With DRAW_RECT_OUTLINE_EN defined, outline=1 and w=h=4: 16 scan cycles with 12 plot cycles, and the pixels (1,1), (2,1), (1,2) and (2,2) are not plotted.
